constant_block_server: RTL
==========================

CONSTANT_BLOCK_SERVER -- requirements
Module: constant_block_server

Interface
REQ-001 SHALL have parameter REGISTER_SIZE, default 32, width in bits of one block.
REQ-002 SHALL have parameter NUM_BLOCKS, default 128, number of blocks in the served constant (128 x 32 = 4096 bits).
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port load_valid_in, input, 1, the current load_block_in is the next constant block, LSB block first.
REQ-006 SHALL have port load_block_in, input, REGISTER_SIZE, constant block being loaded.
REQ-007 SHALL have port load_done_out, output, 1, one-cycle pulse when the last block of a load is written.
REQ-008 SHALL have port ready_out, output, 1, high while a complete constant is being served.
REQ-009 SHALL have port consumed_in, input, 1, one-cycle pulse from the consumer; advances to the next block.
REQ-010 SHALL have port restart_in, input, 1, rewinds serving to block 0.
REQ-011 SHALL have port block_out, output, REGISTER_SIZE, constant block at the current index.
REQ-012 SHALL have port block_index_out, output, $clog2(NUM_BLOCKS), current serve index.
REQ-013 SHALL have port wrap_out, output, 1, one-cycle pulse when the index wraps from NUM_BLOCKS-1 to 0.
REQ-014 SHALL have port error_out, output, 1, sticky protocol-error flag (see Configuration).

Function
REQ-015 SHALL store NUM_BLOCKS blocks in an internal array indexed 0..NUM_BLOCKS-1.
REQ-016 SHALL implement states EMPTY, LOADING, SERVING; exit reset in EMPTY.
REQ-017 SHALL do EMPTY or SERVING -> LOADING on load_valid_in; that block is written to index 0 and the load counter is set to 1.
REQ-018 SHALL do this in LOADING: each load_valid_in writes to the load counter index and increments the counter; gaps between valid cycles are allowed.
REQ-019 SHALL, on the write of index NUM_BLOCKS-1, pulse load_done_out on the next cycle, enter SERVING, and set the serve index to 0.
REQ-020 SHALL keep ready_out high only in SERVING; it goes low the cycle after a new load begins.
REQ-021 SHALL register block_out: the value equals array[index] one cycle after any index change, and block 0 is presented on the first SERVING cycle.
REQ-022 SHALL increment the index on consumed_in in SERVING, modulo NUM_BLOCKS; sustained one-pulse-per-cycle rate is supported.
REQ-023 SHALL, on a wrap (NUM_BLOCKS-1 -> 0), pulse wrap_out in the same cycle block_index_out shows 0.
REQ-024 SHALL set the index to 0 on restart_in in SERVING; restart_in has priority over a simultaneous consumed_in, and no wrap_out pulse is produced.
REQ-025 SHALL ignore consumed_in and restart_in outside SERVING; the index is unchanged.
REQ-026 SHALL treat load_valid_in in SERVING in the same cycle as consumed_in as follows: the load wins and the consume is dropped.
REQ-027 SHALL give block_out, block_index_out, load_done_out and wrap_out no meaning while ready_out is low; they hold their last values.

Reset
REQ-028 SHALL, on rst_in low, immediately (asynchronously) set: state EMPTY, counters 0, block_out 0, block_index_out 0, ready_out 0, load_done_out 0, wrap_out 0, error_out 0.
REQ-029 SHALL not require reset of array contents; after reset, a full reload is required before ready_out rises.
REQ-030 SHALL, on reset during LOADING, abandon the partial load.

Configuration
REQ-031 SHALL use macro CONSTANT_SERVER_ERROR_CHECK_EN to control error checking.
REQ-032 SHALL, when CONSTANT_SERVER_ERROR_CHECK_EN is defined, set error_out and hold it until reset if consumed_in is asserted outside SERVING, or if consumed_in and load_valid_in coincide.
REQ-033 SHALL, when CONSTANT_SERVER_ERROR_CHECK_EN is undefined, tie error_out to 0 and synthesize no checking logic.

Verification
REQ-034 SHALL cover this scenario: NUM_BLOCKS=4, load 0x11,0x22,0x33,0x44 -> load_done_out pulses once, ready_out=1, block_out=0x11, index 0.
REQ-035 SHALL cover this scenario: after load, 4 back-to-back consumed_in -> block_out 0x22,0x33,0x44,0x11 on successive cycles; wrap_out pulses once with index 0.
REQ-036 SHALL cover this scenario: at index 2, consumed_in and restart_in together -> index 0, block_out=0x11, no wrap_out.
REQ-037 SHALL cover this scenario: consumed_in while EMPTY -> index stays 0, ready_out=0; error_out=1 only with the macro defined.
REQ-038 SHALL cover this scenario: reset asserted after 2 of 4 load blocks -> all outputs 0 immediately; a fresh 4-block load of 0xA0..0xA3 serves 0xA0 first.
REQ-039 SHALL cover this scenario: reload 0x55..0x58 while serving at index 3 -> ready_out low during the load, then block_out=0x55 at index 0 after load_done_out.

Source files
------------

// File: rtl/constant_block_server.sv
// rtl/constant_block_server.sv - serves a loaded NUM_BLOCKS x REGISTER_SIZE constant one block at a time
// Optional sticky protocol checking is enabled by defining CONSTANT_SERVER_ERROR_CHECK_EN.
module constant_block_server #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          load_valid_in,
  input  logic [REGISTER_SIZE-1:0]      load_block_in,
  output logic                          load_done_out,
  output logic                          ready_out,
  input  logic                          consumed_in,
  input  logic                          restart_in,
  output logic [REGISTER_SIZE-1:0]      block_out,
  output logic [$clog2(NUM_BLOCKS)-1:0] block_index_out,
  output logic                          wrap_out,
  output logic                          error_out
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {EMPTY, LOADING, SERVING} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         load_cnt;
  logic [IDX_W-1:0]         wr_addr;
  logic [IDX_W-1:0]         next_idx;
  logic [REGISTER_SIZE-1:0] mem [NUM_BLOCKS];

  // Any load beat outside LOADING starts a fresh load at block 0.
  always_comb begin
    wr_addr  = (state == LOADING) ? load_cnt : '0;
    next_idx = (block_index_out == LAST_IDX) ? '0 : block_index_out + IDX_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (load_valid_in) begin
      mem[wr_addr] <= load_block_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= EMPTY;
      load_cnt        <= '0;
      block_out       <= '0;
      block_index_out <= '0;
      ready_out       <= 1'b0;
      load_done_out   <= 1'b0;
      wrap_out        <= 1'b0;
    end else begin
      load_done_out <= 1'b0;
      wrap_out      <= 1'b0;
      case (state)
        EMPTY: begin
          if (load_valid_in) begin
            state    <= LOADING;
            load_cnt <= IDX_W'(1);
          end
        end
        LOADING: begin
          if (load_valid_in) begin
            if (load_cnt == LAST_IDX) begin
              // Block 0 was written at the start of the load, so it can be presented now.
              state           <= SERVING;
              load_cnt        <= '0;
              ready_out       <= 1'b1;
              load_done_out   <= 1'b1;
              block_index_out <= '0;
              block_out       <= mem[0];
            end else begin
              load_cnt <= load_cnt + IDX_W'(1);
            end
          end
        end
        SERVING: begin
          if (load_valid_in) begin
            state     <= LOADING;
            load_cnt  <= IDX_W'(1);
            ready_out <= 1'b0;
          end else if (restart_in) begin
            block_index_out <= '0;
            block_out       <= mem[0];
          end else if (consumed_in) begin
            block_index_out <= next_idx;
            block_out       <= mem[next_idx];
            wrap_out        <= (block_index_out == LAST_IDX);
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef CONSTANT_SERVER_ERROR_CHECK_EN
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      error_out <= 1'b0;
    end else if (consumed_in && ((state != SERVING) || load_valid_in)) begin
      error_out <= 1'b1;
    end
  end
`else
  assign error_out = 1'b0;
`endif

endmodule
